// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for a stable lock,
// then releases the downstream system reset. Runs entirely on refclk.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] lock_loss_count
);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        WAIT_LOCK  = 2'd1,
        STABLE     = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam int T_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int T_MAX = (T_AB > STABLE_CYCLES) ? T_AB : STABLE_CYCLES;
    localparam int TW    = $clog2(T_MAX);

    localparam logic [TW-1:0]    RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]    LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   timer_q;
    logic            sync1_q;
    logic            locked_s;
    logic            retry_inc;
    logic            loss_inc;

    // locked is asynchronous to refclk
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1_q  <= locked;
            locked_s <= sync1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state_q)
            RESET_HOLD: begin
                if (timer_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (timer_q == LOCK_LAST) begin
                    state_d   = RESET_HOLD;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d  = RESET_HOLD;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = RESET_HOLD;
        endcase
    end

    // outputs decode the next state so they move on the same edge as state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q         <= RESET_HOLD;
            timer_q         <= '0;
            retry_count     <= '0;
            lock_loss_count <= '0;
            pll_rst         <= 1'b1;
            sys_rst         <= 1'b1;
            ready           <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (state_q != RUN) begin
                timer_q <= timer_q + 1'b1;
            end
            if (retry_inc && retry_count != CNT_MAX) begin
                retry_count <= retry_count + 1'b1;
            end
            if (loss_inc && lock_loss_count != CNT_MAX) begin
                lock_loss_count <= lock_loss_count + 1'b1;
            end
            pll_rst <= (state_d == RESET_HOLD);
            sys_rst <= (state_d != RUN);
            ready   <= (state_d == RUN);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock
// activity, checked every cycle against a timestamp-based reference model.
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int CNT_W         = 4;
    localparam int CMAX          = (1 << CNT_W) - 1;

    logic             refclk = 1'b0;
    logic             rst;
    logic             locked;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic [1:0]       dut_state;
    logic [CNT_W-1:0] retry_count;
    logic [CNT_W-1:0] lock_loss_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_print  = 0;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .locked         (locked),
        .pll_rst        (pll_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .state          (dut_state),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 refclk = ~refclk;

    // Reference model: phase plus the edge index at which it was entered.
    int cyc     = 0;
    int m_start = 0;
    int m_ph    = 0;
    int m_retry = 0;
    int m_loss  = 0;
    int m_el;
    bit m_ls;
    bit m_sync[2];
    bit m_valid = 1'b0;

    always @(posedge refclk) begin
        cyc++;
        m_ls = m_sync[1];
        if (rst) begin
            m_valid = 1'b1;
            m_ph    = 0;
            m_start = cyc;
            m_retry = 0;
            m_loss  = 0;
            m_sync  = '{1'b0, 1'b0};
        end else begin
            m_el = cyc - m_start - 1;
            if (m_ph == 0 && m_el == RST_CYCLES - 1) begin
                m_ph = 1; m_start = cyc;
            end else if (m_ph == 1 && m_ls) begin
                m_ph = 2; m_start = cyc;
            end else if (m_ph == 1 && m_el == LOCK_TIMEOUT - 1) begin
                m_ph = 0; m_start = cyc;
                m_retry = (m_retry < CMAX) ? m_retry + 1 : CMAX;
            end else if (m_ph == 2 && !m_ls) begin
                m_ph = 1; m_start = cyc;
            end else if (m_ph == 2 && m_el == STABLE_CYCLES - 1) begin
                m_ph = 3; m_start = cyc;
            end else if (m_ph == 3 && !m_ls) begin
                m_ph = 0; m_start = cyc;
                m_loss = (m_loss < CMAX) ? m_loss + 1 : CMAX;
            end
            m_sync[1] = m_sync[0];
            m_sync[0] = locked;
        end
    end

    always @(negedge refclk) begin
        logic [1:0] e_st;
        logic e_pll, e_sys, e_rdy;
        if (m_valid) begin
            e_st  = 2'(m_ph);
            e_pll = (m_ph == 0);
            e_sys = (m_ph != 3);
            e_rdy = (m_ph == 3);
            n_checks++;
            if (dut_state !== e_st || pll_rst !== e_pll || sys_rst !== e_sys ||
                ready !== e_rdy || retry_count !== CNT_W'(m_retry) ||
                lock_loss_count !== CNT_W'(m_loss)) begin
                n_fail++;
                if (n_print < 30) begin
                    n_print++;
                    $display("FAIL model cyc %0d: got st=%0d pll=%0b sys=%0b rdy=%0b rc=%0d lc=%0d required st=%0d pll=%0b sys=%0b rdy=%0b rc=%0d lc=%0d",
                             cyc, dut_state, pll_rst, sys_rst, ready, retry_count,
                             lock_loss_count, e_st, e_pll, e_sys, e_rdy, m_retry, m_loss);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic reset_seq();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    task automatic wait_state(input int st, input int budget, input string name);
        int n;
        n = 0;
        while (int'(dut_state) != st && n < budget) begin
            step(1);
            n++;
        end
        check(name, int'(dut_state), st);
    endtask

    initial begin
        int prev;
        int rises;
        rst    = 1'b1;
        locked = 1'b0;
        @(negedge refclk);

        // normal start
        reset_seq();
        check("t1_pll_n0", pll_rst, 1);
        step(3);
        check("t1_pll_n3", pll_rst, 1);
        step(1);
        check("t1_pll_n4", pll_rst, 0);
        check("t1_wait_n4", dut_state, 1);
        step(1);
        locked = 1'b1;
        step(2);
        check("t1_wait_n7", dut_state, 1);
        step(1);
        check("t1_stable_n8", dut_state, 2);
        step(7);
        check("t1_sys_n15", sys_rst, 1);
        step(1);
        check("t1_sys_n16", sys_rst, 0);
        check("t1_ready", ready, 1);
        check("t1_retry", retry_count, 0);
        check("t1_loss", lock_loss_count, 0);

        // lock loss in RUN
        step(2);
        locked = 1'b0;
        step(2);
        check("t4_ready_n2", ready, 1);
        step(1);
        check("t4_sys", sys_rst, 1);
        check("t4_pll", pll_rst, 1);
        check("t4_ready", ready, 0);
        check("t4_loss", lock_loss_count, 1);
        locked = 1'b1;
        wait_state(3, 100, "t4_rerun");

        // saturation, then rst mid-WAIT_LOCK
        locked = 1'b0;
        step(3 + 17 * (RST_CYCLES + LOCK_TIMEOUT) + 2);
        check("t5_retry_sat", retry_count, 15);
        check("t5_loss", lock_loss_count, 2);
        wait_state(1, 30, "t5_wait");
        step(3);
        rst = 1'b1;
        step(1);
        check("t5_state", dut_state, 0);
        check("t5_retry_clr", retry_count, 0);
        check("t5_loss_clr", lock_loss_count, 0);
        check("t5_pll", pll_rst, 1);
        step(2);

        // glitch in STABLE
        locked = 1'b0;
        reset_seq();
        step(5);
        locked = 1'b1;
        step(3);
        check("t3_stable_n8", dut_state, 2);
        step(5);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(2);
        check("t3_back_wait", dut_state, 1);
        step(1);
        check("t3_restable", dut_state, 2);
        step(7);
        check("t3_still_stable", dut_state, 2);
        step(1);
        check("t3_run", dut_state, 3);
        check("t3_retry", retry_count, 0);

        // tie-break: lock arrives on the timeout cycle
        locked = 1'b0;
        reset_seq();
        step(21);
        locked = 1'b1;
        step(2);
        check("t6_wait_n23", dut_state, 1);
        step(1);
        check("t6_stable", dut_state, 2);
        check("t6_retry", retry_count, 0);

        // never locks
        locked = 1'b0;
        reset_seq();
        prev  = int'(pll_rst);
        rises = 0;
        for (int i = 1; i <= 100; i++) begin
            step(1);
            if (pll_rst && prev == 0) rises++;
            prev = int'(pll_rst);
            if (i == 23) check("t2_wait_n23", dut_state, 1);
            if (i == 24) check("t2_hold_n24", dut_state, 0);
        end
        check("t2_retry", retry_count, 4);
        check("t2_pulses", rises, 4);

        // random lock activity
        reset_seq();
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end
            locked = ($urandom_range(0, 3) != 0);
            step($urandom_range(1, 40));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
